trace_request_decoder: RTL and testbench



---
 rtl/cache_pkg.sv | 55 +++++
 rtl/trace_request_decoder_if.sv | 28 ++
 rtl/req_fifo.sv | 59 +++++
 rtl/trace_request_decoder.sv | 185 ++++++++++++++++++
 tb/tb_trace_request_decoder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared L2 model definitions: trace opcodes, request operation classes,
// address-split widths and the decoder FIFO entry layout.
package cache_pkg;

    localparam int unsigned ADDR_BITS   = 32;
    localparam int unsigned OFFSET_BITS = 6;
    localparam int unsigned INDEX_BITS  = 14;
    localparam int unsigned TAG_BITS    = 12;

    localparam logic [3:0] TRC_L1_READ   = 4'd0;
    localparam logic [3:0] TRC_L1_WRITE  = 4'd1;
    localparam logic [3:0] TRC_L1_IFETCH = 4'd2;
    localparam logic [3:0] TRC_SNP_INV   = 4'd3;
    localparam logic [3:0] TRC_SNP_RD    = 4'd4;
    localparam logic [3:0] TRC_SNP_WR    = 4'd5;
    localparam logic [3:0] TRC_SNP_RFO   = 4'd6;
    localparam logic [3:0] TRC_CLEAR     = 4'd8;
    localparam logic [3:0] TRC_PRINT     = 4'd9;

    // Cache ops fit in 3 bits (the reqOp port); clear/print only live in the FIFO.
    typedef enum logic [3:0] {
        OP_READ    = 4'd0,
        OP_WRITE   = 4'd1,
        OP_IFETCH  = 4'd2,
        OP_SNP_INV = 4'd3,
        OP_SNP_RD  = 4'd4,
        OP_SNP_WR  = 4'd5,
        OP_SNP_RFO = 4'd6,
        OP_CLEAR   = 4'd8,
        OP_PRINT   = 4'd9
    } req_op_e;

    typedef struct packed {
        req_op_e               op;
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] index;
    } fifo_entry_t;

    function automatic logic op_is_ctrl(req_op_e op);
        return (op == OP_CLEAR) || (op == OP_PRINT);
    endfunction

    function automatic logic op_is_read(req_op_e op);
        return (op == OP_READ) || (op == OP_IFETCH) || (op == OP_SNP_RD);
    endfunction

    function automatic logic op_is_snoop(req_op_e op);
        return (op == OP_SNP_INV) || (op == OP_SNP_RD) || (op == OP_SNP_WR) || (op == OP_SNP_RFO);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trace_request_decoder_if.sv
// Trace-command input channel and data-structure request channel of the decoder.
// master = trace reader / downstream side, slave = decoder side.
interface trace_request_decoder_if #(
    parameter int unsigned addrBits  = cache_pkg::ADDR_BITS,
    parameter int unsigned tagBits   = cache_pkg::TAG_BITS,
    parameter int unsigned indexBits = cache_pkg::INDEX_BITS
);
    logic                 cmdValid;
    logic                 cmdReady;
    logic [3:0]           cmd;
    logic [addrBits-1:0]  address;
    logic                 reqValid;
    logic                 reqReady;
    logic [indexBits-1:0] index;
    logic [tagBits-1:0]   addressTag;
    logic                 read;
    logic [2:0]           reqOp;

    modport master (
        output cmdValid, cmd, address, reqReady,
        input  cmdReady, reqValid, index, addressTag, read, reqOp
    );

    modport slave (
        input  cmdValid, cmd, address, reqReady,
        output cmdReady, reqValid, index, addressTag, read, reqOp
    );
endinterface

// File: rtl/req_fifo.sv
// In-order command buffer for the trace decoder; exposes the head and the
// entry behind it so the issuing FSM can look one pop ahead.
module req_fifo
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              push_i,
    input  fifo_entry_t       wdata_i,
    input  logic              pop_i,
    output fifo_entry_t       head_o,
    output fifo_entry_t       next_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[rd_ptr_q + PTR_W'(1)];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/trace_request_decoder.sv
// L2 model front end: decodes trace commands, buffers them in order and issues
// cache ops / control pulses. Statistics counters built only with DECODER_STATS_EN.
module trace_request_decoder
    import cache_pkg::*;
#(
    parameter int unsigned addrBits   = ADDR_BITS,
    parameter int unsigned offsetBits = OFFSET_BITS,
    parameter int unsigned indexBits  = INDEX_BITS,
    parameter int unsigned tagBits    = TAG_BITS,
    parameter int unsigned fifoDepth  = 4
) (
    input  logic                   clk,
    input  logic                   resetN,
    trace_request_decoder_if.slave bus,
    output logic                   clearPulse,
    output logic                   printPulse,
    output logic                   badCmd,
    output logic [31:0]            readCount,
    output logic [31:0]            writeCount,
    output logic [31:0]            snoopCount,
    output logic [31:0]            dropCount
);

    localparam int unsigned CNT_W = $clog2(fifoDepth) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CTRL} state_e;

    state_e           state_q, state_d;
    logic             bad_q, bad_d;
    req_op_e          in_op;
    logic             in_legal, accept, push, drop, pop, issue, handshake;
    fifo_entry_t      wr_entry, head, head_next, after_head;
    logic             after_valid;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             unused_offset;

    assign unused_offset = ^bus.address[offsetBits-1:0];

    always_comb begin
        in_op    = OP_READ;
        in_legal = 1'b1;
        unique case (bus.cmd)
            TRC_L1_READ:   in_op = OP_READ;
            TRC_L1_WRITE:  in_op = OP_WRITE;
            TRC_L1_IFETCH: in_op = OP_IFETCH;
            TRC_SNP_INV:   in_op = OP_SNP_INV;
            TRC_SNP_RD:    in_op = OP_SNP_RD;
            TRC_SNP_WR:    in_op = OP_SNP_WR;
            TRC_SNP_RFO:   in_op = OP_SNP_RFO;
            TRC_CLEAR:     in_op = OP_CLEAR;
            TRC_PRINT:     in_op = OP_PRINT;
            default:       in_legal = 1'b0;
        endcase
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.op    = in_op;
        wr_entry.tag   = bus.address[addrBits-1 -: tagBits];
        wr_entry.index = bus.address[offsetBits +: indexBits];
    end

    assign accept = bus.cmdValid && bus.cmdReady;
    assign push   = accept && in_legal;
    assign drop   = accept && !in_legal;
    assign bad_d  = drop;

    req_fifo #(.DEPTH(fifoDepth)) u_req_fifo (
        .clk     (clk),
        .resetN  (resetN),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .next_o  (head_next),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next state looks at the head as it will be after this edge (including a
    // command pushed now), which gives N+1 issue latency and gap-free streaming.
    always_comb begin
        pop         = 1'b0;
        after_valid = 1'b0;
        after_head  = wr_entry;
        state_d     = ST_IDLE;
        unique case (state_q)
            ST_ISSUE: pop = bus.reqReady;
            ST_CTRL:  pop = 1'b1;
            default:  pop = 1'b0;
        endcase
        if (pop) begin
            if (fifo_count > CNT_W'(1)) begin
                after_valid = 1'b1;
                after_head  = head_next;
            end else begin
                after_valid = push;
            end
        end else if (!fifo_empty) begin
            after_valid = 1'b1;
            after_head  = head;
        end else begin
            after_valid = push;
        end
        if (after_valid) state_d = op_is_ctrl(after_head.op) ? ST_CTRL : ST_ISSUE;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bad_q   <= bad_d;
        end
    end

    assign issue          = (state_q == ST_ISSUE);
    assign handshake      = issue && bus.reqReady;
    assign bus.cmdReady   = !fifo_full;
    assign bus.reqValid   = issue;
    assign bus.index      = issue ? head.index : '0;
    assign bus.addressTag = issue ? head.tag : '0;
    assign bus.read       = issue && op_is_read(head.op);
    assign bus.reqOp      = issue ? 3'(head.op) : '0;
    assign clearPulse     = (state_q == ST_CTRL) && (head.op == OP_CLEAR);
    assign printPulse     = (state_q == ST_CTRL) && (head.op == OP_PRINT);
    assign badCmd         = bad_q;

`ifdef DECODER_STATS_EN
    logic [31:0] read_count_q, read_count_d;
    logic [31:0] write_count_q, write_count_d;
    logic [31:0] snoop_count_q, snoop_count_d;
    logic [31:0] drop_count_q, drop_count_d;

    // A drop accepted during the clear cycle is later in trace order, so it survives the clear.
    always_comb begin
        read_count_d  = read_count_q;
        write_count_d = write_count_q;
        snoop_count_d = snoop_count_q;
        drop_count_d  = drop_count_q;
        if (clearPulse) begin
            read_count_d  = '0;
            write_count_d = '0;
            snoop_count_d = '0;
            drop_count_d  = '0;
        end
        if (handshake) begin
            if (head.op == OP_READ || head.op == OP_IFETCH) read_count_d = sat_inc(read_count_q);
            if (head.op == OP_WRITE) write_count_d = sat_inc(write_count_q);
            if (op_is_snoop(head.op)) snoop_count_d = sat_inc(snoop_count_q);
        end
        if (drop) drop_count_d = sat_inc(drop_count_d);
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            read_count_q  <= '0;
            write_count_q <= '0;
            snoop_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            read_count_q  <= read_count_d;
            write_count_q <= write_count_d;
            snoop_count_q <= snoop_count_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign readCount  = read_count_q;
    assign writeCount = write_count_q;
    assign snoopCount = snoop_count_q;
    assign dropCount  = drop_count_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
    assign readCount  = '0;
    assign writeCount = '0;
    assign snoopCount = '0;
    assign dropCount  = '0;
`endif

endmodule

// File: tb/tb_trace_request_decoder.sv
// Scoreboard bench for trace_request_decoder: expected requests/pulses are queued
// on acceptance and checked in order by a monitor on the falling edge.
module tb_trace_request_decoder;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        clearPulse, printPulse, badCmd;
    logic [31:0] readCount, writeCount, snoopCount, dropCount;

    trace_request_decoder_if bus();

    trace_request_decoder #(
        .addrBits(32), .offsetBits(6), .indexBits(14), .tagBits(12), .fifoDepth(4)
    ) dut (
        .clk(clk), .resetN(resetN), .bus(bus),
        .clearPulse(clearPulse), .printPulse(printPulse), .badCmd(badCmd),
        .readCount(readCount), .writeCount(writeCount),
        .snoopCount(snoopCount), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

`ifdef DECODER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [11:0] tag;
        logic [13:0] idx;
        logic        rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned total = 0, bad = 0;
    int unsigned hs_cnt = 0, clr_cnt = 0, prt_cnt = 0, bad_cnt = 0, cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (resetN) begin
            if (bus.reqValid && bus.reqReady) begin
                hs_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL req_unexpected op=%0d tag=%h idx=%h required=none", bus.reqOp, bus.addressTag, bus.index);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.op > 4'd6 ||
                        {bus.reqOp, bus.addressTag, bus.index, bus.read} !== {mon_e.op[2:0], mon_e.tag, mon_e.idx, mon_e.rd}) begin
                        bad++;
                        $display("FAIL req_order got op=%0d tag=%h idx=%h rd=%b required op=%0d tag=%h idx=%h rd=%b",
                                 bus.reqOp, bus.addressTag, bus.index, bus.read, mon_e.op, mon_e.tag, mon_e.idx, mon_e.rd);
                    end
                end
            end
            if (clearPulse || printPulse) begin
                if (clearPulse) clr_cnt++;
                if (printPulse) prt_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL pulse_unexpected clear=%b print=%b required=none", clearPulse, printPulse);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({clearPulse, printPulse, bus.reqValid} !== {mon_e.op == 4'd8, mon_e.op == 4'd9, 1'b0}) begin
                        bad++;
                        $display("FAIL pulse_order clear=%b print=%b reqValid=%b required op=%0d reqValid=0",
                                 clearPulse, printPulse, bus.reqValid, mon_e.op);
                    end
                end
            end
            if (badCmd) bad_cnt++;
        end
    end

    task automatic do_reset();
        resetN = 1'b0;
        bus.cmdValid = 1'b0;
        bus.reqReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
        exp_q.delete();
        hs_cnt = 0; clr_cnt = 0; prt_cnt = 0; bad_cnt = 0;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a);
        int unsigned n = 0;
        exp_t e;
        bus.cmdValid = 1'b1;
        bus.cmd = c;
        bus.address = a;
        while (!bus.cmdReady && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!bus.cmdReady) begin
            bad++;
            $display("FAIL send_timeout cmdReady=%b required=1", bus.cmdReady);
        end else if (c <= 4'd6 || c == 4'd8 || c == 4'd9) begin
            e.op = c; e.tag = a[31:20]; e.idx = a[19:6];
            e.rd = (c == 4'd0 || c == 4'd2 || c == 4'd4);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.cmdValid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.cmdReady !== 1'b1) begin bad++; $display("FAIL rst_cmdReady got=%b required=1", bus.cmdReady); end
        total++; if (bus.reqValid !== 1'b0) begin bad++; $display("FAIL rst_reqValid got=%b required=0", bus.reqValid); end
        total++; if ({bus.index, bus.addressTag} !== 26'd0) begin bad++; $display("FAIL rst_addr got idx=%h tag=%h required=0", bus.index, bus.addressTag); end
        total++; if ({bus.read, bus.reqOp} !== 4'd0) begin bad++; $display("FAIL rst_op got rd=%b op=%0d required=0", bus.read, bus.reqOp); end
        total++; if ({clearPulse, printPulse, badCmd} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b required=000", {clearPulse, printPulse, badCmd}); end
        total++; if ({readCount, writeCount, snoopCount, dropCount} !== 128'd0) begin bad++; $display("FAIL rst_counters got r=%0d w=%0d s=%0d d=%0d required=0", readCount, writeCount, snoopCount, dropCount); end
    endtask

    task automatic test_first_read();
        do_reset();
        bus.reqReady = 1'b1;
        send(4'd0, 32'h1234_5678);
        total++;
        if ({bus.reqValid, bus.addressTag, bus.index, bus.read, bus.reqOp} !== {1'b1, 12'h123, 14'h1159, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL first_read got v=%b tag=%h idx=%h rd=%b op=%0d required v=1 tag=123 idx=1159 rd=1 op=0",
                     bus.reqValid, bus.addressTag, bus.index, bus.read, bus.reqOp);
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL first_read_drain left=%0d required=0", exp_q.size()); end
    endtask

    task automatic test_full_stall();
        int unsigned gaps = 0;
        logic acc;
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) send(4'd1, {12'hA00 + 12'(i), 14'h100 + 14'(i), 6'h3});
        total++; if (bus.cmdReady !== 1'b0) begin bad++; $display("FAIL full_cmdReady got=%b required=0", bus.cmdReady); end
        bus.cmdValid = 1'b1; bus.cmd = 4'd1; bus.address = {12'hA04, 14'h104, 6'h0};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.cmdReady, bus.reqValid, bus.addressTag, bus.index, bus.reqOp} !== {1'b0, 1'b1, 12'hA00, 14'h100, 3'd1}) begin
                bad++;
                $display("FAIL stall_hold got rdy=%b v=%b tag=%h idx=%h op=%0d required rdy=0 v=1 tag=a00 idx=100 op=1",
                         bus.cmdReady, bus.reqValid, bus.addressTag, bus.index, bus.reqOp);
            end
        end
        bus.reqReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.reqValid !== 1'b1) gaps++;
            acc = bus.cmdValid && bus.cmdReady;
            if (acc) begin
                e.op = 4'd1; e.tag = 12'hA04; e.idx = 14'h104; e.rd = 1'b0;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            if (acc) bus.cmdValid = 1'b0;
        end
        total++; if (gaps != 0) begin bad++; $display("FAIL drain_gaps got=%0d required=0", gaps); end
        total++; if (bus.reqValid !== 1'b0 || exp_q.size() != 0 || bus.cmdValid !== 1'b0) begin
            bad++; $display("FAIL drain_end got v=%b left=%0d pending=%b required v=0 left=0 pending=0", bus.reqValid, exp_q.size(), bus.cmdValid);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.reqReady = 1'b1;
        send(4'd7, 32'hDEAD_BEEF);
        total++; if (badCmd !== 1'b1) begin bad++; $display("FAIL bad_pulse got=%b required=1", badCmd); end
        send(4'd1, 32'h0000_1040);
        total++; if (badCmd !== 1'b0) begin bad++; $display("FAIL bad_single got=%b required=0", badCmd); end
        repeat (4) @(posedge clk);
        #1;
        total++; if (bad_cnt != 1 || hs_cnt != 1) begin bad++; $display("FAIL bad_counts got pulses=%0d issued=%0d required 1 1", bad_cnt, hs_cnt); end
        total++; if (dropCount !== (STATS ? 32'd1 : 32'd0) || writeCount !== (STATS ? 32'd1 : 32'd0)) begin
            bad++; $display("FAIL bad_stats got drop=%0d write=%0d required=%0d", dropCount, writeCount, STATS ? 1 : 0);
        end
    endtask

    task automatic test_clear_print();
        do_reset();
        bus.reqReady = 1'b1;
        send(4'd0, 32'h0000_0040);
        send(4'd8, 32'h0);
        send(4'd2, 32'h0000_0080);
        send(4'd9, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        total++; if (clr_cnt != 1 || prt_cnt != 1) begin bad++; $display("FAIL ctrl_pulses got clear=%0d print=%0d required 1 1", clr_cnt, prt_cnt); end
        total++; if (hs_cnt != 2 || exp_q.size() != 0) begin bad++; $display("FAIL ctrl_issued got=%0d left=%0d required 2 0", hs_cnt, exp_q.size()); end
        total++; if (readCount !== (STATS ? 32'd1 : 32'd0)) begin bad++; $display("FAIL ctrl_readCount got=%0d required=%0d", readCount, STATS ? 1 : 0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) send(4'd5, {12'h0C0 + 12'(i), 14'h20, 6'h0});
        total++; if (bus.reqValid !== 1'b1) begin bad++; $display("FAIL mid_stalled got=%b required=1", bus.reqValid); end
        resetN = 1'b0;
        @(posedge clk); #1;
        resetN = 1'b1;
        exp_q.delete();
        total++; if ({bus.reqValid, bus.cmdReady} !== 2'b01) begin bad++; $display("FAIL mid_reset got v=%b rdy=%b required v=0 rdy=1", bus.reqValid, bus.cmdReady); end
        total++; if ({clearPulse, printPulse, badCmd} !== 3'b000) begin bad++; $display("FAIL mid_pulses got=%b required=000", {clearPulse, printPulse, badCmd}); end
        bus.reqReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (hs_cnt != 0 || bus.reqValid !== 1'b0) begin bad++; $display("FAIL mid_discard got issued=%0d v=%b required 0 0", hs_cnt, bus.reqValid); end
    endtask

    task automatic test_back_to_back();
        int unsigned gaps = 0;
        int unsigned start;
        do_reset();
        bus.reqReady = 1'b1;
        start = cyc;
        for (int i = 0; i < 1000; i++) begin
            send(4'd0, 32'(i) << 6);
            if (bus.reqValid !== 1'b1) gaps++;
        end
        total++; if (cyc - start != 1000) begin bad++; $display("FAIL b2b_cycles got=%0d required=1000", cyc - start); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (gaps != 0 || hs_cnt != 1000) begin bad++; $display("FAIL b2b_issue got gaps=%0d issued=%0d required 0 1000", gaps, hs_cnt); end
        total++; if (readCount !== (STATS ? 32'd1000 : 32'd0)) begin bad++; $display("FAIL b2b_readCount got=%0d required=%0d", readCount, STATS ? 1000 : 0); end
    endtask

    initial begin
        bus.cmdValid = 1'b0;
        bus.cmd = 4'd0;
        bus.address = 32'd0;
        bus.reqReady = 1'b0;
        test_reset();
        test_first_read();
        test_full_stall();
        test_illegal();
        test_clear_print();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
